// File: rtl/focal_scan_sequencer.sv
// Focal scan sequencer: steps paired transducer FIFO/LUT reads through DEPTH focal
// points per line and SCAN_LINES lines per frame, with an idle gap between lines.
module focal_scan_sequencer #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned PTR_LEN    = 4,
   parameter int unsigned SCAN_LINES = 2,
   parameter int unsigned LINE_W     = 4,
   parameter int unsigned LINE_GAP   = 4
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic               fifo_empty_A_in,
   input  logic               fifo_empty_B_in,
   output logic               read_en_fifo_A_out,
   output logic               read_en_fifo_B_out,
   output logic [PTR_LEN-1:0] focal_index_out,
   output logic [LINE_W-1:0]  scan_line_out,
   output logic               line_done_out,
   output logic               frame_done_out,
   output logic               busy_out,
   output logic [15:0]        stall_count_out
);

   localparam int unsigned GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;

   state_t             state, state_nxt;
   logic [PTR_LEN-1:0] focal_nxt;
   logic [LINE_W-1:0]  line_nxt;
   logic [15:0]        stall_nxt;
   logic [GAP_W-1:0]   gap_cnt, gap_nxt;
   logic               line_done_nxt, frame_done_nxt;
   logic               rd_c;

   // State and datapath registers
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         focal_index_out <= '0;
         scan_line_out   <= '0;
         stall_count_out <= '0;
         gap_cnt         <= '0;
         line_done_out   <= 1'b0;
         frame_done_out  <= 1'b0;
      end else begin
         state           <= state_nxt;
         focal_index_out <= focal_nxt;
         scan_line_out   <= line_nxt;
         stall_count_out <= stall_nxt;
         gap_cnt         <= gap_nxt;
         line_done_out   <= line_done_nxt;
         frame_done_out  <= frame_done_nxt;
      end
   end

   // Next-state and read-strobe logic
   always_comb begin
      state_nxt      = state;
      focal_nxt      = focal_index_out;
      line_nxt       = scan_line_out;
      stall_nxt      = stall_count_out;
      gap_nxt        = gap_cnt;
      line_done_nxt  = 1'b0;
      frame_done_nxt = 1'b0;
      rd_c           = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = RUN;
               focal_nxt = '0;
               line_nxt  = '0;
               stall_nxt = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               focal_nxt = '0;
               line_nxt  = '0;
            end else if (!fifo_empty_A_in && !fifo_empty_B_in) begin
               rd_c = 1'b1;
               if (focal_index_out == PTR_LEN'(DEPTH - 1)) begin
                  focal_nxt     = '0;
                  line_done_nxt = 1'b1;
                  if (scan_line_out < LINE_W'(SCAN_LINES - 1)) begin
                     state_nxt = GAP;
                     gap_nxt   = '0;
                  end else begin
                     state_nxt      = DONE;
                     frame_done_nxt = 1'b1;
                  end
               end else begin
                  focal_nxt = focal_index_out + PTR_LEN'(1);
               end
            end else if (stall_count_out != 16'hFFFF) begin
               stall_nxt = stall_count_out + 16'd1;
            end
         end
         GAP: begin
            if (abort) begin
               state_nxt = IDLE;
               focal_nxt = '0;
               line_nxt  = '0;
            end else if (gap_cnt == GAP_W'(LINE_GAP - 1)) begin
               state_nxt = RUN;
               line_nxt  = scan_line_out + LINE_W'(1);
            end else begin
               gap_nxt = gap_cnt + GAP_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
            if (abort) begin
               focal_nxt = '0;
               line_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign read_en_fifo_A_out = rd_c;
   assign read_en_fifo_B_out = rd_c;
   assign busy_out           = (state != IDLE);

endmodule

// File: doc/focal_scan_sequencer.md
FOCAL_SCAN_SEQUENCER -- requirements
Module: focal_scan_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: focal points per scan line.
REQ-002 SHALL have parameter PTR_LEN, default 4: focal index width; DEPTH <= 2**PTR_LEN.
REQ-003 SHALL have parameter SCAN_LINES, default 2: scan lines per frame.
REQ-004 SHALL have parameter LINE_W, default 4: scan line counter width; SCAN_LINES <= 2**LINE_W.
REQ-005 SHALL have parameter LINE_GAP, default 4: idle cycles between lines, >= 1.
REQ-006 SHALL have port Clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  one-cycle frame start request.
REQ-009 SHALL have port abort  input  1  terminate frame immediately.
REQ-010 SHALL have ports fifo_empty_A_in and fifo_empty_B_in  input  1 each  transducer FIFO empty flags.
REQ-011 SHALL have ports read_en_fifo_A_out and read_en_fifo_B_out  output  1 each  paired FIFO/LUT read strobes.
REQ-012 SHALL have port focal_index_out  output  PTR_LEN  focal point index of the next read.
REQ-013 SHALL have port scan_line_out  output  LINE_W  current scan line.
REQ-014 SHALL have ports line_done_out and frame_done_out  output  1 each  one-cycle completion pulses.
REQ-015 SHALL have port busy_out  output  1  high whenever state is not IDLE.
REQ-016 SHALL have port stall_count_out  output  16  RUN cycles spent without a read.

Function
REQ-017 SHALL implement states IDLE, RUN, GAP, DONE.
REQ-018 IDLE -> RUN on start=1 and abort=0; focal_index, scan_line and stall_count clear to 0 on that edge.
REQ-019 In RUN, both read enables SHALL be combinationally 1 exactly when !fifo_empty_A_in & !fifo_empty_B_in & !abort; they SHALL be 0 in every other state.
REQ-020 Read enables A and B SHALL always be identical (paired read, never one-sided).
REQ-021 Each cycle with read enables high SHALL increment focal_index_out by 1 at the next edge.
REQ-022 A read at focal_index = DEPTH-1 SHALL wrap focal_index to 0, pulse line_done_out for the next cycle, and move to GAP if scan_line < SCAN_LINES-1, else to DONE.
REQ-023 A RUN cycle with read enables low and abort=0 SHALL increment stall_count_out, saturating at 16'hFFFF.
REQ-024 GAP SHALL last exactly LINE_GAP cycles, then go to RUN with scan_line incremented by 1 on that transition.
REQ-025 DONE SHALL last one cycle, pulse frame_done_out during it, then go to IDLE.
REQ-026 Latency: first read enable no earlier than the cycle after start; with FIFOs always non-empty one frame takes SCAN_LINES*DEPTH + (SCAN_LINES-1)*LINE_GAP + 2 cycles from start to the IDLE return.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in any non-IDLE state SHALL force IDLE at the next edge, clear focal_index and scan_line, suppress read enables that cycle, and produce no line_done or frame_done pulse; stall_count SHALL hold.
REQ-029 start and abort together in IDLE SHALL leave state IDLE.
REQ-030 Empty flags toggling during GAP or DONE SHALL have no effect.

Reset
REQ-031 reset SHALL asynchronously force IDLE, focal_index_out=0, scan_line_out=0, stall_count_out=0, line_done_out=0, frame_done_out=0, busy_out=0, read enables 0.
REQ-032 reset mid-frame SHALL abandon the frame without any pulse; operation resumes only on a new start after reset deasserts.

Verification
REQ-033 Defaults, FIFOs never empty, start pulse -> 16 consecutive paired reads for index 0..15, line_done, 4-cycle gap, 16 reads on line 1, frame_done, 38 cycles start-to-IDLE, stall_count=0.
REQ-034 fifo_empty_B_in high for 3 cycles at index 5 -> both enables low for 3 cycles, index holds 5, stall_count=3.
REQ-035 abort at index 9 of line 1 -> enables low same cycle, IDLE next, index=0, line=0, no frame_done.
REQ-036 start re-pulsed while busy, and start+abort in IDLE -> no state change, no extra reads.
REQ-037 reset asserted asynchronously mid-RUN between edges -> all outputs at reset values immediately, before next Clk edge.
REQ-038 FIFO A held empty for 70000 RUN cycles -> stall_count saturates at 16'hFFFF, no reads issued.
